// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode types: opcodes, ALU op and format enums, decoded bundle struct.
// Imported by rv_decode_comb and decode_stage.
package rv_decode_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_COPY_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        alu_src_imm;
    logic        reg_wen;
    logic        is_break;
    logic        illegal;
  } dec_t;

  // alt selects SUB/SRA, i.e. funct7[5] on the encodings where it is meaningful
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I/RV32E instruction decoder; no state, zero latency.
// Illegal encodings yield an all-zero bundle with only the illegal flag set.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic [31:0] i_inst,
  output dec_t        o_dec
);

  localparam logic RV32E = (NREG == 16);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  fmt_e        w_fmt;
  alu_op_e     w_op;
  logic        w_legal;
  logic        w_use1;
  logic        w_use2;
  logic        w_hasrd;
  logic        w_brk;
  logic [31:0] w_imm;

  assign w_opc = i_inst[6:0];
  assign w_f3  = i_inst[14:12];
  assign w_f7  = i_inst[31:25];

  always_comb begin
    w_fmt   = FMT_I;
    w_op    = ALU_ADD;
    w_legal = 1'b1;
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    w_hasrd = 1'b0;
    w_brk   = 1'b0;
    case (w_opc)
      OPC_OP_IMM: begin
        w_use1  = 1'b1;
        w_hasrd = 1'b1;
        w_op    = alu_from_f3(w_f3, i_inst[30] && (w_f3 == 3'b101));
        if (w_f3 == 3'b001)      w_legal = (w_f7 == 7'h00);
        else if (w_f3 == 3'b101) w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
      end
      OPC_OP: begin
        w_fmt   = FMT_R;
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_hasrd = 1'b1;
        w_op    = alu_from_f3(w_f3, i_inst[30]);
        w_legal = (w_f7 == 7'h00) ||
                  ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      end
      OPC_LUI: begin
        w_fmt   = FMT_U;
        w_hasrd = 1'b1;
        w_op    = ALU_COPY_B;
      end
      OPC_AUIPC: begin
        w_fmt   = FMT_U;
        w_hasrd = 1'b1;
      end
      OPC_JAL: begin
        w_fmt   = FMT_J;
        w_hasrd = 1'b1;
      end
      OPC_JALR: begin
        w_use1  = 1'b1;
        w_hasrd = 1'b1;
        w_legal = (w_f3 == 3'b000);
      end
      OPC_LOAD: begin
        w_use1  = 1'b1;
        w_hasrd = 1'b1;
        w_legal = (w_f3 != 3'b011) && (w_f3[2:1] != 2'b11);
      end
      OPC_STORE: begin
        w_fmt   = FMT_S;
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_legal = !w_f3[2] && (w_f3 != 3'b011);
      end
      OPC_BRANCH: begin
        w_fmt   = FMT_B;
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_op    = ALU_SUB;
        w_legal = (w_f3[2:1] != 2'b01);
      end
      OPC_SYSTEM: begin
        w_legal = (i_inst == INST_ECALL) || (i_inst == INST_EBREAK);
        w_brk   = (i_inst == INST_EBREAK);
      end
      default: w_legal = 1'b0;
    endcase
    // RV32E only has x0..x15, so bit 4 of any register index actually read or written is illegal
    if (RV32E && ((w_use1 && i_inst[19]) || (w_use2 && i_inst[24]) || (w_hasrd && i_inst[11])))
      w_legal = 1'b0;
  end

  always_comb begin
    w_imm = '0;
    case (w_fmt)
      FMT_I:   w_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      FMT_S:   w_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      FMT_B:   w_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      FMT_U:   w_imm = {i_inst[31:12], 12'b0};
      FMT_J:   w_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  always_comb begin
    o_dec = '0;
    if (w_legal) begin
      o_dec.rs1         = w_use1  ? i_inst[19:15] : 5'd0;
      o_dec.rs2         = w_use2  ? i_inst[24:20] : 5'd0;
      o_dec.rd          = w_hasrd ? i_inst[11:7]  : 5'd0;
      o_dec.imm         = w_imm;
      o_dec.alu_op      = w_op;
      o_dec.alu_src_imm = (w_fmt != FMT_R) && (w_fmt != FMT_B);
      o_dec.reg_wen     = w_hasrd && (i_inst[11:7] != 5'd0);
      o_dec.is_break    = w_brk;
    end else begin
      o_dec.illegal     = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: 1-cycle latency, full throughput, in_ready drops when output is stalled or halted.
// Sticky halt after EBREAK/illegal until rst; DECODE_PERF_EN adds transfer/illegal counters.
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output alu_op_e         out_alu_op,
  output logic            out_alu_src_imm,
  output logic            out_reg_wen,
  output logic            out_is_break,
  output logic            out_illegal,
  output logic            halted
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]     perf_inst_cnt,
  output logic [31:0]     perf_illegal_cnt
`endif
);

  dec_t            w_dec;
  logic            w_xfer;
  dec_t            r_dec;
  logic [PC_W-1:0] r_pc;
  logic            r_vld;
  logic            r_halted;

  rv_decode_comb #(.NREG(NREG)) u_comb (
    .i_inst (in_inst),
    .o_dec  (w_dec)
  );

  assign in_ready = !r_halted && (!r_vld || out_ready);
  assign w_xfer   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec    <= '0;
      r_pc     <= '0;
      r_vld    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_dec <= w_dec;
        r_pc  <= in_pc;
        r_vld <= 1'b1;
      end else if (out_ready) begin
        r_vld <= 1'b0;
      end
      if (w_xfer && (w_dec.is_break || w_dec.illegal))
        r_halted <= 1'b1;
    end
  end

  assign out_valid       = r_vld;
  assign out_pc          = r_pc;
  assign out_rs1         = r_dec.rs1;
  assign out_rs2         = r_dec.rs2;
  assign out_rd          = r_dec.rd;
  assign out_imm         = r_dec.imm;
  assign out_alu_op      = r_dec.alu_op;
  assign out_alu_src_imm = r_dec.alu_src_imm;
  assign out_reg_wen     = r_dec.reg_wen;
  assign out_is_break    = r_dec.is_break;
  assign out_illegal     = r_dec.illegal;
  assign halted          = r_halted;

`ifdef DECODE_PERF_EN
  logic [31:0] r_inst_cnt;
  logic [31:0] r_ill_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst_cnt <= '0;
      r_ill_cnt  <= '0;
    end else if (w_xfer) begin
      r_inst_cnt <= r_inst_cnt + 32'd1;
      if (w_dec.illegal)
        r_ill_cnt <= r_ill_cnt + 32'd1;
    end
  end

  assign perf_inst_cnt    = r_inst_cnt;
  assign perf_illegal_cnt = r_ill_cnt;
`endif

endmodule
